simon_round_sequencer: RTL

//  Game controller for the Simon Says datapath on Basys3. Latches a 16-entry 2-bit colour sequence,

---
 rtl/simon_pkg.sv | 33 +++
 rtl/simon_round_sequencer_if.sv | 30 +++
 rtl/phase_timer.sv | 26 ++
 rtl/simon_round_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared Simon Says types: colour codes, sizes and controller state encoding.
// Reused by the round sequencer, display and button blocks.
package simon_pkg;

  localparam int COLOR_W = 2;
  localparam int MAX_LEN = 16;
  localparam int IDX_W   = $clog2(MAX_LEN);
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int SEQ_W   = COLOR_W * MAX_LEN;

  localparam logic [COLOR_W-1:0] RED    = 2'd0;
  localparam logic [COLOR_W-1:0] GREEN  = 2'd1;
  localparam logic [COLOR_W-1:0] BLUE   = 2'd2;
  localparam logic [COLOR_W-1:0] YELLOW = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_INPUT,
    S_ROUND_GAP,
    S_LOSE,
    S_WIN
  } state_e;

  function automatic logic [COLOR_W-1:0] color_at(
    input logic [SEQ_W-1:0] seq,
    input logic [IDX_W-1:0] idx
  );
    return seq[idx*COLOR_W +: COLOR_W];
  endfunction

endpackage

// File: rtl/simon_round_sequencer_if.sv
// Game-control bundle between sequence source, buttons, display and sequencer.
// master drives start/colours/presses; slave is the sequencer.
interface simon_round_sequencer_if;
  import simon_pkg::*;

  logic               start;
  logic [SEQ_W-1:0]   colors;
  logic               btn_valid;
  logic [COLOR_W-1:0] btn_color;
  logic               led_en;
  logic [COLOR_W-1:0] led_color;
  logic [LEN_W-1:0]   round_len;
  logic [LEN_W-1:0]   score;
  logic               busy;
  logic               game_over;
  logic               win;

  modport master (
    output start, colors, btn_valid, btn_color,
    input  led_en, led_color, round_len, score,
    input  busy, game_over, win
  );

  modport slave (
    input  start, colors, btn_valid, btn_color,
    output led_en, led_color, round_len, score,
    output busy, game_over, win
  );

endinterface

// File: rtl/phase_timer.sv
// Phase up-counter: cleared on demand, flags when it sits on the
// terminal count supplied for the current phase.
module phase_timer #(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] tc_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == tc_i);

endmodule

// File: rtl/simon_round_sequencer.sv
// Simon Says round controller: plays the first N colours, then checks
// the player's presses, growing N each completed round.
module simon_round_sequencer
  import simon_pkg::*;
#(
  parameter int SHOW_TICKS    = 25000000,
  parameter int GAP_TICKS     = 12500000,
  parameter int TIMEOUT_TICKS = 250000000,
  parameter int CNT_W         = 28
) (
  input logic                    clk,
  input logic                    reset,
  simon_round_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] TC_SHOW = CNT_W'(SHOW_TICKS - 1);
  localparam logic [CNT_W-1:0] TC_GAP  = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] TC_TO   = CNT_W'(TIMEOUT_TICKS - 1);

  state_e             state_q, state_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   score_q, score_d;
  logic               led_en_q, led_en_d;
  logic [COLOR_W-1:0] led_color_q, led_color_d;
  logic               busy_q, busy_d;
  logic               over_q, over_d;
  logic               win_q, win_d;

  logic             done;
  logic             clr;
  logic             echo;
  logic             last;
  logic             hit;
  logic             idle_st;
  logic [CNT_W-1:0] tc;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (clr),
    .tc_i   (tc),
    .done_o (done)
  );

  assign last    = (LEN_W'(idx_q) + 1'b1) == len_q;
  assign hit     = bus.btn_color == color_at(seq_q, idx_q);
  assign idle_st = state_q inside {S_IDLE, S_LOSE, S_WIN};

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    idx_d   = idx_q;
    len_d   = len_q;
    score_d = score_q;
    echo    = 1'b0;
    tc      = TC_GAP;
    unique case (state_q)
      S_IDLE, S_LOSE, S_WIN: begin
        if (bus.start) begin
          seq_d   = bus.colors;
          len_d   = LEN_W'(1);
          score_d = '0;
          idx_d   = '0;
          state_d = S_ROUND_GAP;
        end
      end
      S_ROUND_GAP: begin
        if (done) begin
          idx_d   = '0;
          state_d = S_SHOW_ON;
        end
      end
      S_SHOW_ON: begin
        tc = TC_SHOW;
        if (done) state_d = S_SHOW_OFF;
      end
      S_SHOW_OFF: begin
        if (done) begin
          if (last) begin
            idx_d   = '0;
            state_d = S_INPUT;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SHOW_ON;
          end
        end
      end
      S_INPUT: begin
        tc = TC_TO;
        // A press on the timeout cycle takes priority over the timeout.
        if (bus.btn_valid) begin
          if (!hit) begin
            state_d = S_LOSE;
          end else if (last) begin
            score_d = len_q;
            if (len_q == LEN_W'(MAX_LEN)) begin
              state_d = S_WIN;
            end else begin
              len_d   = len_q + 1'b1;
              state_d = S_ROUND_GAP;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            echo  = 1'b1;
          end
        end else if (done) begin
          state_d = S_LOSE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    clr = idle_st || (state_d != state_q) ||
          (state_q == S_INPUT && bus.btn_valid);

    led_en_d    = 1'b0;
    led_color_d = led_color_q;
    if (state_d == S_SHOW_ON) begin
      led_en_d    = 1'b1;
      led_color_d = color_at(seq_d, idx_d);
    end else if (echo) begin
      led_en_d    = 1'b1;
      led_color_d = bus.btn_color;
    end else if (state_q == S_INPUT && state_d == S_INPUT) begin
      led_en_d = led_en_q;
    end

    busy_d = !(state_d inside {S_IDLE, S_LOSE, S_WIN});
    over_d = state_d == S_LOSE;
    win_d  = state_d == S_WIN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      seq_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      score_q     <= '0;
      led_en_q    <= 1'b0;
      led_color_q <= '0;
      busy_q      <= 1'b0;
      over_q      <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      score_q     <= score_d;
      led_en_q    <= led_en_d;
      led_color_q <= led_color_d;
      busy_q      <= busy_d;
      over_q      <= over_d;
      win_q       <= win_d;
    end
  end

  assign bus.led_en    = led_en_q;
  assign bus.led_color = led_color_q;
  assign bus.round_len = len_q;
  assign bus.score     = score_q;
  assign bus.busy      = busy_q;
  assign bus.game_over = over_q;
  assign bus.win       = win_q;

endmodule
